// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the MEM stage access controller
package mem_access_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int TIMEOUT_CYC_DEF = 256;

   // Word accesses only: either low address bit set is a misaligned op.
   function automatic logic isAligned(input logic [1:0] addrLow);
      return addrLow == 2'b00;
   endfunction

endpackage

// File: rtl/mem_access_wb_reg.sv
// rtl/mem_access_wb_reg.sv - MEM/WB pipeline register with load and bubble controls
module mem_wb_reg (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        load,
   input  logic        bubble,
   input  logic        rdLoad,
   input  logic        regWrite,
   input  logic        memToReg,
   input  logic [31:0] aluResult,
   input  logic [31:0] rdData,
   input  logic [4:0]  rdAddr,
   output logic        regWriteQ,
   output logic        memToRegQ,
   output logic [31:0] aluResultQ,
   output logic [31:0] readDataQ,
   output logic [4:0]  rdAddrQ
);

   // A bubble only kills the control bits; data fields keep their last value.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         regWriteQ  <= 1'b0;
         memToRegQ  <= 1'b0;
         aluResultQ <= '0;
         readDataQ  <= '0;
         rdAddrQ    <= '0;
      end else if (bubble) begin
         regWriteQ <= 1'b0;
         memToRegQ <= 1'b0;
      end else if (load) begin
         regWriteQ  <= regWrite;
         memToRegQ  <= memToReg;
         aluResultQ <= aluResult;
         rdAddrQ    <= rdAddr;
         if (rdLoad) begin
            readDataQ <= rdData;
         end
      end
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: issues data-memory requests, stalls the pipe, feeds MEM/WB
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] RDData_i,
   input  logic [4:0]  RDaddr_i,
   input  logic        RegWrite_i,
   input  logic        MemToReg_i,
   input  logic        MemWrite_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        RegWrite_o,
   output logic        MemToReg_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] ReadData_o,
   output logic [4:0]  RDaddr_o,
   output logic        err_o
);

   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   state_t        state;
   state_t        nextState;
   logic [CW-1:0] waitCnt;
   logic          memOp;
   logic          aligned;
   logic          timeout;
   logic          stallRaw;
   logic          issue;
   logic          done;
   logic          wbLoad;
   logic          wbBubble;
   logic          rdLoad;
   logic          errSet;

   assign memOp   = MemWrite_i | MemToReg_i;
   assign aligned = isAligned(ALUResult_i[1:0]);
   // An ack on the timeout cycle takes priority, so timeout is qualified by !ack.
   assign timeout = (waitCnt == CW'(TIMEOUT_CYC - 1)) && !mem_ack_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (memOp && aligned) nextState = BUSY;
         BUSY: if (mem_ack_i || timeout) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      stallRaw = 1'b0;
      issue    = 1'b0;
      done     = 1'b0;
      wbLoad   = 1'b0;
      wbBubble = 1'b0;
      rdLoad   = 1'b0;
      errSet   = 1'b0;
      case (state)
         IDLE: begin
            if (!memOp) begin
               wbLoad = 1'b1;
            end else if (aligned) begin
               stallRaw = 1'b1;
               issue    = 1'b1;
               wbBubble = 1'b1;
            end else begin
               wbBubble = 1'b1;
               errSet   = 1'b1;
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               done   = 1'b1;
               wbLoad = 1'b1;
               rdLoad = MemToReg_i;
            end else if (timeout) begin
               done     = 1'b1;
               wbBubble = 1'b1;
               errSet   = 1'b1;
            end else begin
               stallRaw = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign stall_o = stallRaw & rst_n_i;

   // Request fields are captured once at issue and only req drops on completion.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         err_o       <= 1'b0;
      end else begin
         err_o <= errSet;
         if (issue) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= ALUResult_i;
            mem_wdata_o <= RDData_i;
         end else if (done) begin
            mem_req_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         waitCnt <= '0;
      end else if (issue) begin
         waitCnt <= '0;
      end else if (state == BUSY && !done) begin
         waitCnt <= waitCnt + CW'(1);
      end
   end

   mem_wb_reg uWbReg (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load       (wbLoad),
      .bubble     (wbBubble),
      .rdLoad     (rdLoad),
      .regWrite   (RegWrite_i),
      .memToReg   (MemToReg_i),
      .aluResult  (ALUResult_i),
      .rdData     (mem_rdata_i),
      .rdAddr     (RDaddr_i),
      .regWriteQ  (RegWrite_o),
      .memToRegQ  (MemToReg_o),
      .aluResultQ (ALUResult_o),
      .readDataQ  (ReadData_o),
      .rdAddrQ    (RDaddr_o)
   );

endmodule
